glitch_filter_delay: RTL and testbench
======================================

Name: glitch_filter_delay

Overview:
- Synchronous clocked counterpart of the delay-behaviour study block; sits directly downstream of its async pulse outputs (ai/bi-style signals).
- Synchronizes an asynchronous level input, then applies a clocked inertial-delay filter: a level change reaches the output only after it has been stable for FILT_CYC cycles. Shorter pulses are swallowed and counted.
- Also provides a pure synchronized copy of the input (transport-style) and one-cycle pulses on the filtered edges.

Parameters:
- SYNC_STAGES, 2, number of flops in the input synchronizer chain (legal 2..4).
- FILT_CYC, 4, minimum stable width in clk cycles for a level change to propagate (legal >= 2).
- CNT_W, 8, width of the saturating rejected-glitch counter.

Ports:
- clk  input  1  single system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  1  asynchronous level input, may glitch.
- clr  input  1  synchronous clear of rej_cnt.
- dout_sync  output  1  last synchronizer stage; din delayed by SYNC_STAGES edges, no filtering.
- dout_filt  output  1  filtered level.
- rise_pls  output  1  one-cycle pulse, high in the first cycle dout_filt is 1.
- fall_pls  output  1  one-cycle pulse, high in the first cycle dout_filt is 0.
- busy  output  1  high while a level change is being qualified.
- rej_cnt  output  CNT_W  number of rejected pulses/glitches, saturating.

Behaviour:
- Reset, asynchronous and effective immediately: synchronizer chain = 0, state = STABLE_LO, qualification counter = 0, dout_sync = 0, dout_filt = 0, rise_pls = 0, fall_pls = 0, busy = 0, rej_cnt = 0.
- Synchronizer: plain shift chain of SYNC_STAGES flops. dout_sync is the last stage.
- Qualification counter width: clog2(FILT_CYC+1).
- FSM states:
  - STABLE_LO: dout_filt = 0.
  - QUAL_HI: candidate rise; busy = 1.
  - STABLE_HI: dout_filt = 1.
  - QUAL_LO: candidate fall; busy = 1.
- STABLE_LO -> QUAL_HI when dout_sync = 1; counter := 1.
- In QUAL_HI, while dout_sync = 1: counter increments each edge.
  - When the counter would reach FILT_CYC, go to STABLE_HI, set dout_filt := 1 and rise_pls := 1 on that edge, clear the counter.
  - Net effect: dout_filt rises exactly FILT_CYC edges after dout_sync rises.
- In QUAL_HI, if dout_sync = 0: return to STABLE_LO, clear the counter, increment rej_cnt (reject).
- STABLE_HI / QUAL_LO mirror the above with polarities swapped; fall_pls is asserted on the edge that clears dout_filt.
- Width rule:
  - A dout_sync pulse of exactly FILT_CYC cycles passes, as a FILT_CYC-cycle pulse delayed by FILT_CYC.
  - A pulse of FILT_CYC-1 cycles or less is rejected.
- rise_pls and fall_pls are registered, last exactly one cycle, and are never high together.
- rej_cnt saturates at 2^CNT_W-1 and does not wrap.
- clr = 1 sets rej_cnt := 0 on that edge. If clr and a reject occur on the same edge, clr wins (result 0).
- Reset asserted mid-qualification discards the qualification: no pulse output, rej_cnt not incremented.
- If din is already high at reset release, it is re-qualified from scratch.
  - dout_filt rises SYNC_STAGES+FILT_CYC edges after release, with rise_pls.
- Total latency din -> dout_filt: SYNC_STAGES+FILT_CYC edges, ±1 edge for asynchronous sampling.

Test Plan:
- Reset, with clk 10 ns, defaults, din = 0: all outputs 0 during and after reset; 20 idle cycles -> busy = 0, no pulses.
- Short pulse: din high 3 cycles -> dout_sync high 3 cycles; dout_filt stays 0; busy high 3 cycles; rej_cnt 0->1; rise_pls never asserted.
- Pass pulse: din high 4 cycles -> dout_filt high exactly 4 cycles, starting 4 edges after dout_sync rises; rise_pls and fall_pls one cycle each, aligned to the dout_filt edges; rej_cnt unchanged.
- Low glitch while high: din held high 10 cycles, then low 2 cycles, then high again -> dout_filt stays 1 throughout, no fall_pls, rej_cnt +1.
- Saturation/clear: 260 rejected 2-cycle glitches -> rej_cnt = 255 and holds. Pulse clr on the same edge as a reject -> rej_cnt = 0. Next reject -> 1.
- Reset mid-qualification: din rises, rst_n low after 2 QUAL_HI cycles -> all outputs 0 immediately. Release with din still high -> dout_filt = 1 and rise_pls exactly 6 edges after release; rej_cnt = 0.

Source files
------------

// File: rtl/glitch_filter_delay.sv
// glitch_filter_delay: synchronizer plus clocked inertial-delay filter with edge pulses and a glitch counter
module glitch_filter_delay #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             clr,
  output logic             dout_sync,
  output logic             dout_filt,
  output logic             rise_pls,
  output logic             fall_pls,
  output logic             busy,
  output logic [CNT_W-1:0] rej_cnt
);
  localparam int QW = $clog2(FILT_CYC + 1);
  localparam logic [QW-1:0] LAST = QW'(FILT_CYC - 1);
  localparam logic [QW-1:0] ONE  = QW'(1);
  typedef enum logic [1:0] {STABLE_LO, QUAL_HI, STABLE_HI, QUAL_LO} state_t;
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [QW-1:0]          cnt_q, cnt_d;
  logic [CNT_W-1:0]       rej_q, rej_d;
  logic                   filt_q, filt_d, rise_q, rise_d, fall_q, fall_d, rej_ev, s;
  assign s         = sync_q[SYNC_STAGES-1];
  assign dout_sync = s;
  assign dout_filt = filt_q;
  assign rise_pls  = rise_q;
  assign fall_pls  = fall_q;
  assign busy      = (state_q == QUAL_HI) || (state_q == QUAL_LO);
  assign rej_cnt   = rej_q;
  // next state: a candidate level must hold FILT_CYC sampled edges, otherwise it is rejected
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], din};
    state_d = state_q;
    cnt_d   = '0;
    filt_d  = filt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    rej_ev  = 1'b0;
    case (state_q)
      STABLE_LO: if (s) begin
        state_d = QUAL_HI;
        cnt_d   = ONE;
      end
      QUAL_HI: if (!s) begin
        state_d = STABLE_LO;
        rej_ev  = 1'b1;
      end else if (cnt_q == LAST) begin
        state_d = STABLE_HI;
        filt_d  = 1'b1;
        rise_d  = 1'b1;
      end else cnt_d = cnt_q + ONE;
      STABLE_HI: if (!s) begin
        state_d = QUAL_LO;
        cnt_d   = ONE;
      end
      QUAL_LO: if (s) begin
        state_d = STABLE_HI;
        rej_ev  = 1'b1;
      end else if (cnt_q == LAST) begin
        state_d = STABLE_LO;
        filt_d  = 1'b0;
        fall_d  = 1'b1;
      end else cnt_d = cnt_q + ONE;
      default: state_d = STABLE_LO;
    endcase
    rej_d = clr ? '0 : (rej_ev && rej_q != '1) ? rej_q + 1'b1 : rej_q;
  end
  // state registers; reset drops any qualification in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      filt_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      rej_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      filt_q  <= filt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      rej_q   <= rej_d;
    end
  end
endmodule

// File: tb/tb_glitch_filter_delay.sv
// tb_glitch_filter_delay: directed stimulus with a run-length reference model feeding a per-cycle scoreboard
module tb_glitch_filter_delay;
  localparam int F = 4;
  logic clk = 1'b0, rst_n = 1'b0, din = 1'b0, clr = 1'b0;
  logic dout_sync, dout_filt, rise_pls, fall_pls, busy;
  logic [7:0] rej_cnt;
  int n_pass = 0, n_tot = 0;
  logic [12:0] sb[$];
  logic [1:0] m_sh = '0;
  logic m_filt = 1'b0;
  int m_run = 0, m_rej = 0;
  int hi_len = 0, rise_seen = 0;

  glitch_filter_delay dut (
    .clk(clk), .rst_n(rst_n), .din(din), .clr(clr),
    .dout_sync(dout_sync), .dout_filt(dout_filt), .rise_pls(rise_pls),
    .fall_pls(fall_pls), .busy(busy), .rej_cnt(rej_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] obs();
    return {dout_sync, dout_filt, rise_pls, fall_pls, busy, rej_cnt};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_tot++;
    assert (o === e) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, o, e);
  endtask

  task automatic model_rst();
    m_sh = '0;
    m_filt = 1'b0;
    m_run = 0;
    m_rej = 0;
  endtask

  // called at a falling edge: drive, predict the next rising edge, compare just after it
  task automatic step(input logic d, input logic c = 1'b0);
    logic s, r, f, rej_ev;
    din = d;
    clr = c;
    s = m_sh[1];
    r = 1'b0;
    f = 1'b0;
    rej_ev = 1'b0;
    if (s != m_filt) begin
      m_run++;
      if (m_run == F) begin
        m_filt = s;
        r = s;
        f = !s;
        m_run = 0;
      end
    end else begin
      rej_ev = (m_run > 0);
      m_run = 0;
    end
    m_rej = c ? 0 : (rej_ev && m_rej < 255) ? m_rej + 1 : m_rej;
    m_sh = {m_sh[0], d};
    sb.push_back({m_sh[1], m_filt, r, f, m_run > 0, 8'(m_rej)});
    @(posedge clk);
    #1;
    chk("cycle", obs(), sb.pop_front());
    hi_len += dout_filt;
    rise_seen += rise_pls;
    @(negedge clk);
  endtask

  initial begin
    #1 chk("reset_async", obs(), 13'd0);
    repeat (3) @(posedge clk);
    #1 chk("reset_held", obs(), 13'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_rst();
    repeat (20) step(1'b0);
    chk("idle_busy", busy, 0);
    // short pulse: FILT_CYC-1 cycles is swallowed
    rise_seen = 0;
    repeat (3) step(1'b1);
    repeat (6) step(1'b0);
    chk("short_rej", rej_cnt, 1);
    chk("short_no_rise", rise_seen, 0);
    // exactly FILT_CYC cycles passes with its width preserved
    hi_len = 0;
    rise_seen = 0;
    repeat (4) step(1'b1);
    repeat (10) step(1'b0);
    chk("pass_width", hi_len, 4);
    chk("pass_rise", rise_seen, 1);
    chk("pass_rej", rej_cnt, 1);
    // low glitch while high
    repeat (10) step(1'b1);
    repeat (2) step(1'b0);
    repeat (8) step(1'b1);
    chk("hold_hi", dout_filt, 1);
    chk("glitch_rej", rej_cnt, 2);
    repeat (10) step(1'b0);
    chk("back_lo", dout_filt, 0);
    // saturation
    for (int i = 0; i < 260; i++) begin
      step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    end
    repeat (4) step(1'b0);
    chk("sat", rej_cnt, 255);
    // clr coincides with the reject edge
    step(1'b1); step(1'b1); step(1'b0); step(1'b0); step(1'b0, 1'b1);
    chk("clr_wins", rej_cnt, 0);
    step(1'b1); step(1'b1); step(1'b0); step(1'b0); step(1'b0);
    chk("after_clr", rej_cnt, 1);
    // reset during qualification, din still high at release
    repeat (4) step(1'b1);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1 chk("mid_rst_async", obs(), 13'd0);
    @(posedge clk);
    #1 chk("mid_rst_held", obs(), 13'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_rst();
    repeat (5) step(1'b1);
    chk("rel_not_yet", dout_filt, 0);
    step(1'b1);
    chk("rel_rise", {dout_filt, rise_pls}, 2'b11);
    chk("rel_rej", rej_cnt, 0);
    repeat (10) step(1'b0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
